iob_cache_fe_seq: RTL and testbench

//  Front-end initiator for the cache's IOb native slave port: the request side that the cache answers.
//  On start it writes a deterministic pattern to N consecutive word addresses, then reads them back and compares.
//  It drives req/addr/wdata/wstrb, waits for ack and checks rdata.
//  It sits in the simulation wrapper, in FPGA self-test tops, or in front of iob_cache.

---
 rtl/iob_cache_fe_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_iob_cache_fe_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_fe_seq.sv
// Self-test initiator for the IOb cache front end: writes SEED+i to N consecutive
// word addresses, reads them back, and reports mismatches, first bad address and timeout.
//
// state    | meaning
// ---------+----------------------------------------------------
// S_IDLE   | waiting for a start rising edge; results held
// S_WR_REQ | write request outstanding, waiting for ack
// S_WR_GAP | one idle cycle after a write ack
// S_RD_REQ | read request outstanding, rdata checked on ack
// S_RD_GAP | one idle cycle after a read ack
// S_FIN    | publish done/pass, then back to idle
module iob_cache_fe_seq #(
  parameter int                ADDR_W    = 30,
  parameter int                DATA_W    = 32,
  parameter int                N_W       = 10,
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(32'hA5A50000),
  parameter int                TIMEOUT_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [N_W-1:0]      n_words,
  output logic                req,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ack,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_W-1:0]      err_cnt,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_REQ = 3'd1;
  localparam logic [2:0] S_WR_GAP = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_GAP = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [N_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                start_q;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_W-1:0]      err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                timeout_q, timeout_d;

  logic                 start_acc;
  logic [N_W:0]         idx_inc;
  logic                 more;
  logic [TIMEOUT_W-1:0] tmo_inc;
  logic [DATA_W-1:0]    expect_data;

  assign start_acc   = start & ~start_q & (state_q == S_IDLE);
  assign idx_inc     = {1'b0, idx_q} + (N_W+1)'(1);
  assign more        = idx_inc < {1'b0, n_q};
  assign tmo_inc     = tmo_q + TIMEOUT_W'(1);
  assign expect_data = SEED + DATA_W'(idx_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    n_d        = n_q;
    tmo_d      = tmo_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          base_d     = base_addr;
          n_d        = n_words;
          idx_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          if (n_words == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_WR_REQ;
            req_d   = 1'b1;
            addr_d  = base_addr;
            wdata_d = SEED;
            wstrb_d = '1;
            tmo_d   = '0;
          end
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = (state_q == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
          if ((state_q == S_RD_REQ) && (rdata != expect_data)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + N_W'(1);
            if (err_cnt_q == '0) err_addr_d = addr_q;
          end
        end else if (tmo_inc == '1) begin
          // Abort: a late ack lands in FIN/IDLE and is ignored there.
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_WR_GAP: begin
        req_d = 1'b1;
        tmo_d = '0;
        if (more) begin
          idx_d   = idx_inc[N_W-1:0];
          addr_d  = base_q + ADDR_W'(idx_inc);
          wdata_d = SEED + DATA_W'(idx_inc);
          wstrb_d = '1;
          state_d = S_WR_REQ;
        end else begin
          idx_d   = '0;
          addr_d  = base_q;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_GAP: begin
        if (more) begin
          idx_d   = idx_inc[N_W-1:0];
          addr_d  = base_q + ADDR_W'(idx_inc);
          wdata_d = '0;
          wstrb_d = '0;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == '0) && !timeout_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      base_q     <= '0;
      n_q        <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      n_q        <= n_d;
      tmo_q      <= tmo_d;
      start_q    <= start;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign req      = req_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign wstrb    = wstrb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_iob_cache_fe_seq.sv
// Directed bench for iob_cache_fe_seq with a small behavioural IOb RAM responder.
module tb_iob_cache_fe_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [29:0] base_addr;
  logic [9:0]  n_words;
  logic        req;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack;
  logic        busy, done, pass, timeout;
  logic [9:0]  err_cnt;
  logic [29:0] err_addr;

  int checks = 0;
  int errors = 0;

  // responder controls
  logic never_ack = 1'b0;
  logic rand_dly  = 1'b0;
  logic corrupt_en = 1'b0;
  logic late_ack  = 1'b0;
  int   wait_cnt  = 0;
  int   dly_cur   = 0;
  logic [31:0] mem [64];
  logic corrupt_hit;

  // monitor state
  logic [29:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [29:0] rd_a[$];
  int   req_rises = 0;
  int   req_hi_cnt = 0;
  int   stab_err = 0;
  logic req_prev = 1'b0;
  logic pend_prev = 1'b0;
  logic [29:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wstrb;

  always #5 clk = ~clk;

  iob_cache_fe_seq dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_words(n_words),
    .req(req), .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ack(ack),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_addr(err_addr),
    .timeout(timeout)
  );

  assign corrupt_hit = corrupt_en && (addr == 30'h12 || addr == 30'h15);
  assign rdata = mem[addr[5:0]] ^ {31'b0, corrupt_hit};
  assign ack = late_ack | (req && !never_ack && (wait_cnt >= dly_cur));

  always @(posedge clk) begin
    if (req && ack) begin
      wait_cnt <= 0;
      dly_cur  <= rand_dly ? int'($urandom_range(0, 7)) : 0;
    end else if (req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    if (req) req_hi_cnt = req_hi_cnt + 1;
    if (req && !req_prev) req_rises = req_rises + 1;
    if (req && pend_prev && (addr !== p_addr || wdata !== p_wdata || wstrb !== p_wstrb))
      stab_err = stab_err + 1;
    if (req && ack) begin
      if (wstrb == 4'hF) begin
        mem[addr[5:0]] = wdata;
        wr_a.push_back(addr);
        wr_d.push_back(wdata);
      end else begin
        rd_a.push_back(addr);
      end
    end
    req_prev  = req;
    pend_prev = req && !ack;
    p_addr    = addr;
    p_wdata   = wdata;
    p_wstrb   = wstrb;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    req_rises  = 0;
    req_hi_cnt = 0;
    stab_err   = 0;
  endtask

  // Start is raised before a posedge; cycles counts posedges up to the one after which done is seen.
  task automatic run(input logic [29:0] b, input logic [9:0] n, input int limit,
                     output int cycles, output bit to);
    @(negedge clk);
    base_addr = b;
    n_words   = n;
    start     = 1'b1;
    cycles    = 0;
    to        = 1'b0;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      cycles = cycles + 1;
      if (done) break;
      if (cycles >= limit) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b expected 0", req);
    end
    checks++;
    if ({addr, wdata, wstrb, busy, done, pass, err_cnt, err_addr, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%h wdata=%h wstrb=%h busy=%b done=%b pass=%b err_cnt=%0d err_addr=%h timeout=%b expected all 0",
               addr, wdata, wstrb, busy, done, pass, err_cnt, err_addr, timeout);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    bit to;
    clear_logs();
    run(30'h10, 10'd8, 200, cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_run: no done within 200 cycles"); end
    checks++;
    if (cyc != 34) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 34", cyc); end
    checks++;
    if ({done, pass, busy, timeout} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_flags: done=%b pass=%b busy=%b timeout=%b expected 1 1 0 0", done, pass, busy, timeout);
    end
    checks++;
    if (err_cnt !== 10'd0) begin errors++; $display("FAIL basic_err_cnt: got %0d expected 0", err_cnt); end
    checks++;
    if (wr_a.size() != 8 || rd_a.size() != 8) begin
      errors++;
      $display("FAIL basic_counts: writes=%0d reads=%0d expected 8 8", wr_a.size(), rd_a.size());
    end
    for (int i = 0; i < wr_a.size() && i < 8; i++) begin
      checks++;
      if (wr_a[i] !== 30'h10 + 30'(i) || wr_d[i] !== 32'hA5A50000 + 32'(i)) begin
        errors++;
        $display("FAIL basic_write%0d: addr=%h data=%h expected %h %h", i, wr_a[i], wr_d[i],
                 30'h10 + 30'(i), 32'hA5A50000 + 32'(i));
      end
    end
    checks++;
    if (rd_a.size() == 8 && (rd_a[0] !== 30'h10 || rd_a[7] !== 30'h17)) begin
      errors++;
      $display("FAIL basic_read_addr: first=%h last=%h expected 10 17", rd_a[0], rd_a[7]);
    end
    checks++;
    if (req_rises != 16) begin errors++; $display("FAIL basic_req_count: got %0d expected 16", req_rises); end
  endtask

  task automatic test_corrupt();
    int cyc;
    bit to;
    clear_logs();
    corrupt_en = 1'b1;
    run(30'h10, 10'd8, 200, cyc, to);
    corrupt_en = 1'b0;
    checks++;
    if (to || done !== 1'b1) begin errors++; $display("FAIL corrupt_done: done=%b to=%b expected 1 0", done, to); end
    checks++;
    if (pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b expected 0", pass); end
    checks++;
    if (err_cnt !== 10'd2) begin errors++; $display("FAIL corrupt_err_cnt: got %0d expected 2", err_cnt); end
    checks++;
    if (err_addr !== 30'h12) begin errors++; $display("FAIL corrupt_err_addr: got %h expected 12", err_addr); end
  endtask

  task automatic test_timeout();
    int cyc;
    bit to;
    clear_logs();
    never_ack = 1'b1;
    run(30'h10, 10'd4, 5000, cyc, to);
    checks++;
    if (to) begin errors++; $display("FAIL timeout_run: no done within 5000 cycles"); end
    checks++;
    if (req_hi_cnt != 4095) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 4095", req_hi_cnt); end
    checks++;
    if ({done, timeout, pass, req} !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_flags: done=%b timeout=%b pass=%b req=%b expected 1 1 0 0", done, timeout, pass, req);
    end
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    repeat (10) @(negedge clk);
    never_ack = 1'b0;
    checks++;
    if (req_hi_cnt != 4095 || req_rises != 1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: req_cycles=%0d rises=%0d done=%b busy=%b expected 4095 1 1 0",
               req_hi_cnt, req_rises, done, busy);
    end
  endtask

  task automatic test_zero_and_wrap();
    int cyc;
    bit to;
    clear_logs();
    run(30'h10, 10'd0, 20, cyc, to);
    checks++;
    if (to || cyc != 2) begin errors++; $display("FAIL zero_latency: got %0d cycles expected 2", cyc); end
    checks++;
    if ({done, pass, timeout, busy} !== 4'b1100 || req_rises != 0) begin
      errors++;
      $display("FAIL zero_flags: done=%b pass=%b timeout=%b busy=%b rises=%0d expected 1 1 0 0 0",
               done, pass, timeout, busy, req_rises);
    end
    clear_logs();
    run(30'h3FFFFFFF, 10'd3, 100, cyc, to);
    checks++;
    if (to || pass !== 1'b1) begin errors++; $display("FAIL wrap_pass: pass=%b to=%b expected 1 0", pass, to); end
    checks++;
    if (wr_a.size() != 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes expected 3", wr_a.size());
    end else if (wr_a[0] !== 30'h3FFFFFFF || wr_a[1] !== 30'h0 || wr_a[2] !== 30'h1) begin
      errors++;
      $display("FAIL wrap_addrs: got %h %h %h expected 3fffffff 0 1", wr_a[0], wr_a[1], wr_a[2]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    int n;
    @(negedge clk);
    base_addr = 30'h10;
    n_words   = 10'd8;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(req && wstrb == 4'h0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(req && wstrb == 4'h0)) begin errors++; $display("FAIL rstmid_reach_read: req=%b wstrb=%h expected 1 0", req, wstrb); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({req, addr, wdata, wstrb, busy, done, pass, err_cnt, err_addr, timeout} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: req=%b addr=%h wdata=%h wstrb=%h busy=%b done=%b expected all 0",
               req, addr, wdata, wstrb, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    run(30'h10, 10'd8, 200, cyc, to);
    checks++;
    if (to || cyc != 34 || pass !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_rerun: cycles=%0d pass=%b to=%b expected 34 1 0", cyc, pass, to);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_logs();
    rand_dly = 1'b1;
    @(negedge clk);
    base_addr = 30'h20;
    n_words   = 10'd6;
    start     = 1'b1;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin start = 1'b0; base_addr = 30'h30; end
      if (cyc == 10) start = 1'b1;
      if (cyc == 12) start = 1'b0;
      if (done || cyc >= 500) break;
    end
    start = 1'b0;
    rand_dly = 1'b0;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL b2b_pass: done=%b pass=%b expected 1 1", done, pass); end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL b2b_stable: got %0d changes while req high expected 0", stab_err); end
    checks++;
    if (wr_a.size() != 6 || rd_a.size() != 6 || req_rises != 12) begin
      errors++;
      $display("FAIL b2b_counts: writes=%0d reads=%0d rises=%0d expected 6 6 12", wr_a.size(), rd_a.size(), req_rises);
    end
    checks++;
    if (rd_a.size() == 6 && (rd_a[0] !== 30'h20 || rd_a[5] !== 30'h25)) begin
      errors++;
      $display("FAIL b2b_addrs: first=%h last=%h expected 20 25", rd_a[0], rd_a[5]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    start     = 1'b0;
    base_addr = '0;
    n_words   = '0;
    test_reset();
    test_basic();
    test_corrupt();
    test_timeout();
    test_zero_and_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
